// File: rtl/dmem_responder_pkg.sv
// Shared pipeline definitions: responder FSM encoding, MEM-stage control-bundle
// bit layout and the data word width.
package dmem_responder_pkg;

    localparam int WORD_W = 32;

    localparam int MEM_READ_BIT  = 0;
    localparam int MEM_WRITE_BIT = 1;
    localparam int BRANCH_BIT    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    // A word access must sit on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x WORD_W storage: synchronous write, registered read.
// Contents are never cleared.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Storage write port and read-data register; rdata holds when re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[index] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[index];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: stalls the pipeline for
// LATENCY cycles per access, then pulses resp_valid with the load result.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] write_data,
    output logic [WORD_W-1:0] read_data,
    output logic              resp_valid,
    output logic              mem_stall,
    output logic              addr_err
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_write_q, op_write_d;
    logic              illegal_q, illegal_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              resp_valid_q;
    logic              addr_err_q;
    logic [WORD_W-1:0] read_data_q;

    logic              req_s;
    logic              live_illegal_s;
    logic [IDX_W-1:0]  live_idx_s;
    logic              stall_s;
    logic              arr_we_s;
    logic              arr_re_s;
    logic [IDX_W-1:0]  arr_idx_s;
    logic [WORD_W-1:0] arr_rdata_s;
    logic [WORD_W-1:0] rd_now_s;
    logic              show_rd_s;

    assign req_s          = MemRead | MemWrite;
    assign live_idx_s     = address[IDX_W+1:2];
    assign live_illegal_s = is_misaligned(address) ||
                            ({2'b00, address[WORD_W-1:2]} >= 32'(DEPTH));

    // cnt holds the stall cycles still owed after the current one, so a zero
    // load (LATENCY of 1) goes straight from IDLE to DONE.
    // Next-state, capture and array-strobe logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        illegal_d  = illegal_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        stall_s    = 1'b0;
        arr_we_s   = 1'b0;
        arr_re_s   = 1'b0;
        arr_idx_s  = idx_q;
        case (state_q)
            IDLE: begin
                arr_idx_s = live_idx_s;
                if (req_s) begin
                    stall_s    = 1'b1;
                    op_write_d = MemWrite;
                    illegal_d  = live_illegal_s;
                    idx_d      = live_idx_s;
                    wdata_d    = write_data;
                    cnt_d      = CNT_LOAD;
                    if (CNT_LOAD == 4'd0) begin
                        state_d  = DONE;
                        arr_re_s = ~MemWrite & ~live_illegal_s;
                    end else begin
                        state_d  = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d  = DONE;
                    arr_re_s = ~op_write_q & ~illegal_q;
                end else begin
                    state_d  = BUSY;
                end
            end
            DONE: begin
                arr_we_s = op_write_q & ~illegal_q;
                cnt_d    = 4'd0;
                state_d  = IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State, captured request and registered response flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            op_write_q   <= 1'b0;
            illegal_q    <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            read_data_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_write_q   <= op_write_d;
            illegal_q    <= illegal_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= (state_d == DONE);
            addr_err_q   <= (state_d == DONE) & illegal_d;
            if (show_rd_s) begin
                read_data_q <= rd_now_s;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s & ~reset),
        .re    (arr_re_s & ~reset),
        .index (arr_idx_s),
        .wdata (wdata_q),
        .rdata (arr_rdata_s)
    );

    // The array read register lands in the DONE cycle; expose it directly
    // there and keep a held copy for the cycles after.
    assign show_rd_s  = (state_q == DONE) & ~op_write_q;
    assign rd_now_s   = illegal_q ? 32'h0000_0000 : arr_rdata_s;
    assign read_data  = (show_rd_s & ~reset) ? rd_now_s : read_data_q;
    assign resp_valid = resp_valid_q & ~reset;
    assign addr_err   = addr_err_q & ~reset;
    assign mem_stall  = stall_s & ~reset;

endmodule
